mul_sequencer: RTL and testbench

MUL_SEQUENCER -- requirements
Module: mul_sequencer

---
 rtl/mul_sequencer_pkg.sv | 19 +
 rtl/mul_sequencer_alu.sv | 59 +++++
 rtl/mul_sequencer.sv | 126 ++++++++++++
 tb/tb_mul_sequencer.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/mul_sequencer_pkg.sv
// Shared ALU definitions: opcode encodings and flag bit positions.
// Used by the datapath ALU and every unit that drives it.
package mul_sequencer_pkg;

    localparam logic [3:0] ALU_ADD = 4'h0;
    localparam logic [3:0] ALU_ADC = 4'h1;
    localparam logic [3:0] ALU_SUB = 4'h2;
    localparam logic [3:0] ALU_AND = 4'h3;
    localparam logic [3:0] ALU_OR  = 4'h4;
    localparam logic [3:0] ALU_XOR = 4'h5;
    localparam logic [3:0] ALU_SHL = 4'h6;
    localparam logic [3:0] ALU_SHR = 4'h7;

    localparam int FLAG_Z = 0;
    localparam int FLAG_C = 1;
    localparam int FLAG_N = 2;
    localparam int FLAG_V = 3;

endpackage

// File: rtl/mul_sequencer_alu.sv
// Datapath ALU: combinational result and V,N,C,Z flags.
// Shifts report the last bit shifted out in C.
module mul_sequencer_alu
    import mul_sequencer_pkg::*;
#(
    parameter int DataWidth = 16,
    parameter int FlagBits  = 4
) (
    input  logic [DataWidth-1:0] a,
    input  logic [DataWidth-1:0] b,
    input  logic [3:0]           op,
    input  logic [FlagBits-1:0]  iflags,
    output logic [DataWidth-1:0] y,
    output logic [FlagBits-1:0]  oflags
);

    logic [DataWidth:0] ext;
    logic [DataWidth:0] shr;
    logic               v;
    logic               unused_iflags;

    assign unused_iflags = ^iflags;
    assign shr = {a, 1'b0} >> b;

    always_comb begin
        ext = '0;
        v   = 1'b0;
        unique case (op)
            ALU_ADD: ext = {1'b0, a} + {1'b0, b};
            ALU_ADC: ext = {1'b0, a} + {1'b0, b}
                         + {{DataWidth{1'b0}}, iflags[FLAG_C]};
            ALU_SUB: ext = {1'b0, a} - {1'b0, b};
            ALU_AND: ext = {1'b0, a & b};
            ALU_OR:  ext = {1'b0, a | b};
            ALU_XOR: ext = {1'b0, a ^ b};
            ALU_SHL: ext = {1'b0, a} << b;
            // carry-out sits in bit 0 of shr; rotate into the MSB slot
            ALU_SHR: ext = {shr[0], shr[DataWidth:1]};
            default: ext = '0;
        endcase
        if (op == ALU_ADD || op == ALU_ADC)
            v = (a[DataWidth-1] == b[DataWidth-1])
              && (ext[DataWidth-1] != a[DataWidth-1]);
        else if (op == ALU_SUB)
            v = (a[DataWidth-1] != b[DataWidth-1])
              && (ext[DataWidth-1] != a[DataWidth-1]);
    end

    assign y = ext[DataWidth-1:0];

    always_comb begin
        oflags         = '0;
        oflags[FLAG_V] = v;
        oflags[FLAG_N] = ext[DataWidth-1];
        oflags[FLAG_C] = ext[DataWidth];
        oflags[FLAG_Z] = (ext[DataWidth-1:0] == '0);
    end

endmodule

// File: rtl/mul_sequencer.sv
// Unsigned shift-add multiplier sequencer; all Hi arithmetic and
// shifting is delegated to the external datapath ALU.
module mul_sequencer
    import mul_sequencer_pkg::*;
#(
    parameter int DataWidth = 16,
    parameter int FlagBits  = 4
) (
    input  logic                   Clock,
    input  logic                   Reset_N,
    input  logic                   Start,
    input  logic [DataWidth-1:0]   MulA,
    input  logic [DataWidth-1:0]   MulB,
    output logic                   Busy,
    output logic                   Done,
    output logic [2*DataWidth-1:0] Product,
    output logic [DataWidth-1:0]   AluA,
    output logic [DataWidth-1:0]   AluB,
    output logic [3:0]             AluOp,
    output logic [FlagBits-1:0]    AluIFlags,
    input  logic [DataWidth-1:0]   AluY,
    input  logic [FlagBits-1:0]    AluOFlags
);

    localparam int CntW = $clog2(DataWidth) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADD,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t              state;
    logic [DataWidth-1:0] hi;
    logic [DataWidth-1:0] lo;
    logic [DataWidth-1:0] m;
    logic                 cr;
    logic [CntW-1:0]      cnt;

    logic [DataWidth-1:0] hi_shr;
    logic [DataWidth-1:0] lo_shr;
    logic                 last;
    logic                 unused_flags;

    assign unused_flags = ^AluOFlags;

    // add carry re-enters at the top of Hi; Hi's LSB drops into Lo
    assign hi_shr = {cr, AluY[DataWidth-2:0]};
    assign lo_shr = {AluOFlags[FLAG_C], lo[DataWidth-1:1]};
    assign last   = (cnt == CntW'(DataWidth - 1));

    assign AluIFlags = '0;

    always_comb begin
        AluA  = '0;
        AluB  = '0;
        AluOp = ALU_ADD;
        unique case (state)
            S_ADD: begin
                AluA = hi;
                AluB = m;
            end
            S_SHIFT: begin
                AluA  = hi;
                AluB  = DataWidth'(1);
                AluOp = ALU_SHR;
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset_N) begin
        if (!Reset_N) begin
            state   <= S_IDLE;
            hi      <= '0;
            lo      <= '0;
            m       <= '0;
            cr      <= 1'b0;
            cnt     <= '0;
            Busy    <= 1'b0;
            Done    <= 1'b0;
            Product <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    Done <= 1'b0;
                    if (Start) begin
                        m     <= MulA;
                        hi    <= '0;
                        lo    <= MulB;
                        cr    <= 1'b0;
                        cnt   <= '0;
                        Busy  <= 1'b1;
                        state <= MulB[0] ? S_ADD : S_SHIFT;
                    end
                end
                S_ADD: begin
                    hi    <= AluY;
                    cr    <= AluOFlags[FLAG_C];
                    state <= S_SHIFT;
                end
                S_SHIFT: begin
                    hi  <= hi_shr;
                    lo  <= lo_shr;
                    cr  <= 1'b0;
                    cnt <= cnt + CntW'(1);
                    if (last) begin
                        Product <= {hi_shr, lo_shr};
                        Busy    <= 1'b0;
                        Done    <= 1'b1;
                        state   <= S_DONE;
                    end else begin
                        state <= lo[1] ? S_ADD : S_SHIFT;
                    end
                end
                S_DONE: begin
                    Done  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_sequencer.sv
// Directed bench: mul_sequencer wired to the datapath ALU at 16 bits.
module tb_mul_sequencer;
    import mul_sequencer_pkg::*;

    localparam int DW = 16;
    localparam int FB = 4;

    logic          Clock;
    logic          Reset_N;
    logic          Start;
    logic [DW-1:0] MulA;
    logic [DW-1:0] MulB;
    logic          Busy;
    logic          Done;
    logic [2*DW-1:0] Product;
    logic [DW-1:0] AluA;
    logic [DW-1:0] AluB;
    logic [3:0]    AluOp;
    logic [FB-1:0] AluIFlags;
    logic [DW-1:0] AluY;
    logic [FB-1:0] AluOFlags;

    int checks;
    int failures;
    int done_cnt;

    mul_sequencer #(.DataWidth(DW), .FlagBits(FB)) dut (
        .Clock    (Clock),
        .Reset_N  (Reset_N),
        .Start    (Start),
        .MulA     (MulA),
        .MulB     (MulB),
        .Busy     (Busy),
        .Done     (Done),
        .Product  (Product),
        .AluA     (AluA),
        .AluB     (AluB),
        .AluOp    (AluOp),
        .AluIFlags(AluIFlags),
        .AluY     (AluY),
        .AluOFlags(AluOFlags)
    );

    mul_sequencer_alu #(.DataWidth(DW), .FlagBits(FB)) alu (
        .a     (AluA),
        .b     (AluB),
        .op    (AluOp),
        .iflags(AluIFlags),
        .y     (AluY),
        .oflags(AluOFlags)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    always @(posedge Clock) if (Done) done_cnt++;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Returns edges from the Start-sampling edge until Done is seen.
    task automatic wait_done(output int lat);
        lat = -1;
        for (int k = 1; k <= 100; k++) begin
            @(posedge Clock);
            #1;
            if (Done) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic run(input string tag, input logic [DW-1:0] a,
                       input logic [DW-1:0] b, input logic [2*DW-1:0] exp,
                       input int exp_lat);
        int lat;
        @(negedge Clock);
        MulA  = a;
        MulB  = b;
        Start = 1'b1;
        @(posedge Clock);
        #1;
        Start = 1'b0;
        chk({tag, "_busy"}, 64'(Busy), 64'd1);
        wait_done(lat);
        chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        chk({tag, "_prod"}, 64'(Product), 64'(exp));
        @(posedge Clock);
        #1;
        chk({tag, "_pulse"}, 64'(Done), 64'd0);
        chk({tag, "_idle"}, 64'(Busy), 64'd0);
    endtask

    initial begin
        int lat;
        checks   = 0;
        failures = 0;
        done_cnt = 0;
        Reset_N  = 1'b0;
        Start    = 1'b0;
        MulA     = '0;
        MulB     = '0;
        #1;
        chk("rst_busy", 64'(Busy), 64'd0);
        chk("rst_done", 64'(Done), 64'd0);
        chk("rst_prod", 64'(Product), 64'd0);
        chk("rst_aluop", 64'(AluOp), 64'(ALU_ADD));
        chk("rst_alua", 64'(AluA), 64'd0);
        repeat (2) @(posedge Clock);
        @(negedge Clock);
        Reset_N = 1'b1;
        @(posedge Clock);
        #1;
        chk("idle_busy", 64'(Busy), 64'd0);

        run("m3x5", 16'd3, 16'd5, 32'h0000_000F, 18);
        run("mffff", 16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 32);
        run("mzero", 16'h1234, 16'h0000, 32'h0, 16);
        run("m1234", 16'h1234, 16'h5678, 32'h0626_0060, 24);
        run("m8000", 16'h8000, 16'h8000, 32'h4000_0000, 17);
        run("azero", 16'h0000, 16'hFFFF, 32'h0, 32);

        // Start held high with changing operands during the run
        done_cnt = 0;
        @(negedge Clock);
        MulA  = 16'h00FF;
        MulB  = 16'h0101;
        Start = 1'b1;
        @(posedge Clock);
        #1;
        MulA = 16'hAAAA;
        MulB = 16'h5555;
        chk("hold_iflags", 64'(AluIFlags), 64'd0);
        wait_done(lat);
        Start = 1'b0;
        chk("hold_lat", 64'(lat), 64'd18);
        chk("hold_prod", 64'(Product), 64'h0000_FFFF);
        repeat (2) @(posedge Clock);
        #1;
        chk("hold_ndone", 64'(done_cnt), 64'd1);
        chk("hold_idle", 64'(Busy), 64'd0);
        run("hold_next", 16'hFFFF, 16'h0001, 32'h0000_FFFF, 17);

        // Reset in the middle of a long run
        done_cnt = 0;
        @(negedge Clock);
        MulA  = 16'hFFFF;
        MulB  = 16'hFFFF;
        Start = 1'b1;
        @(posedge Clock);
        #1;
        Start = 1'b0;
        repeat (5) @(posedge Clock);
        #1;
        Reset_N = 1'b0;
        #1;
        chk("abort_busy", 64'(Busy), 64'd0);
        chk("abort_prod", 64'(Product), 64'd0);
        chk("abort_done", 64'(Done), 64'd0);
        @(negedge Clock);
        Reset_N = 1'b1;
        repeat (40) @(posedge Clock);
        #1;
        chk("abort_ndone", 64'(done_cnt), 64'd0);
        run("m7x9", 16'd7, 16'd9, 32'h0000_003F, 18);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
